// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: finds the start bit, samples each data bit at
// mid-bit on the oversample tick, and checks the stop bit. Each data bit
// goes out as one shift strobe to an external right-shift register. Frame
// completion and framing errors are reported as single-clock pulses.
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16,
    parameter int SB_TICKS  = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic s_tick,
    input  logic rx,
    output logic shift_en,
    output logic shift_din,
    output logic rx_done_tick,
    output logic frame_err,
    output logic busy
);

    localparam int SC_MAX = (OVS > SB_TICKS) ? OVS : SB_TICKS;
    localparam int SCW    = $clog2(SC_MAX);
    localparam int NW     = $clog2(DATA_BITS);

    // Terminal counts for each phase of the frame
    localparam logic [SCW-1:0] MID_START = SCW'(OVS / 2 - 1);
    localparam logic [SCW-1:0] MID_DATA  = SCW'(OVS - 1);
    localparam logic [SCW-1:0] STOP_END  = SCW'(SB_TICKS - 1);
    localparam logic [NW-1:0]  LAST_BIT  = NW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e         state_q, state_d;
    logic [SCW-1:0] s_cnt_q, s_cnt_d;
    logic [NW-1:0]  n_q, n_d;
    logic           shift_en_q, shift_en_d;
    logic           shift_din_q, shift_din_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    // State, counters and registered outputs; reset abandons any frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            n_q         <= '0;
            shift_en_q  <= 1'b0;
            shift_din_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_q         <= n_d;
            shift_en_q  <= shift_en_d;
            shift_din_q <= shift_din_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next state and counters; everything but the IDLE start detect waits on s_tick
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == MID_START) begin
                        // Still low at mid start bit: a real start, else a glitch
                        if (!rx) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SCW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == MID_DATA) begin
                        s_cnt_d = '0;
                        if (n_q == LAST_BIT) state_d = STOP;
                        else                 n_d     = n_q + NW'(1);
                    end else begin
                        s_cnt_d = s_cnt_q + SCW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_END) state_d = IDLE;
                    else                     s_cnt_d = s_cnt_q + SCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output strobes for the next clock; shift_din holds between strobes
    always_comb begin
        shift_en_d  = 1'b0;
        shift_din_d = shift_din_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            DATA: begin
                if (s_tick && s_cnt_q == MID_DATA) begin
                    shift_en_d  = 1'b1;
                    shift_din_d = rx;
                end
            end
            STOP: begin
                // Done fires even on a bad stop bit so the host always sees the frame end
                if (s_tick && s_cnt_q == STOP_END) begin
                    done_d = 1'b1;
                    err_d  = ~rx;
                end
            end
            default: ;
        endcase
    end

    assign shift_en     = shift_en_q;
    assign shift_din    = shift_din_q;
    assign rx_done_tick = done_q;
    assign frame_err    = err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames driven at 64 clk per bit, a model
// right-shift register fed by the strobes, and a scoreboard of expected
// frames popped on each rx_done_tick.
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic s_tick;
    logic rx;
    logic shift_en, shift_din, rx_done_tick, frame_err, busy;

    uart_rx_ctrl #(.DATA_BITS(8), .OVS(16), .SB_TICKS(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .shift_en     (shift_en),
        .shift_din    (shift_din),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_reg;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] reg_val;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   sh_total = 0;
    int   done_total = 0;
    int   mark = 0;
    bit   tick_en = 1'b1;
    logic [7:0] sreg = 8'h00;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Oversample tick: one clk high every 4 clk, gated by tick_en
    initial begin
        int ph;
        ph = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            ph = ph + 1;
            s_tick = tick_en && (ph % 4 == 0);
        end
    end

    // External right-shift register: new bit enters at the MSB
    always @(posedge clk)
        if (shift_en) sreg <= {shift_din, sreg[7:1]};

    // Monitor: count strobes, check each completed frame against the scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            mark = sh_total;
        end else begin
            if (shift_en) sh_total++;
            if (frame_err && !rx_done_tick) chk(1'b0, "err_without_done", 1, 0);
            if (rx_done_tick) begin
                done_total++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(sreg == e.reg_val, "frame_reg", sreg, e.reg_val);
                    chk(frame_err == e.err, "frame_err", frame_err, e.err);
                    chk(sh_total - mark == 8, "strobe_count", sh_total - mark, 8);
                end
                mark = sh_total;
            end
        end
    end

    // Drive one frame; optionally abort after N strobes or stall ticks mid-DATA
    task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_at,
                              input bit stall, output bit aborted);
        int base;
        int w;
        aborted = 1'b0;
        base = sh_total;
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            for (int c = 0; c < 64; c++) begin
                if (stall && i == 3 && c == 20) begin
                    int s0;
                    bit quiet;
                    s0 = sh_total;
                    quiet = 1'b1;
                    tick_en = 1'b0;
                    repeat (200) begin
                        @(negedge clk);
                        if (shift_en || rx_done_tick || !busy) quiet = 1'b0;
                    end
                    tick_en = 1'b1;
                    chk(quiet && sh_total == s0, "stall_hold", sh_total - s0, 0);
                end
                @(negedge clk);
                if (abort_at > 0 && sh_total - base >= abort_at) begin
                    aborted = 1'b1;
                    return;
                end
            end
        end
        rx = stop;
        w = 0;
        while (!rx_done_tick && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk(rx_done_tick == 1'b1, "done_seen", w, 0);
        rx = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] r, input logic e);
        exp_t x;
        x.reg_val = r;
        x.err = e;
        exp_q.push_back(x);
    endtask

    initial begin
        vec_t vecs[4];
        bit   ab;
        int   nt, s0, d0;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_reg: 8'hA5, exp_err: 1'b0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_reg: 8'h3C, exp_err: 1'b1};
        vecs[2] = '{data: 8'h81, stop: 1'b1, exp_reg: 8'h81, exp_err: 1'b0};
        vecs[3] = '{data: 8'h7E, stop: 1'b0, exp_reg: 8'h7E, exp_err: 1'b1};

        // Reset state
        reset_n = 1'b0;
        rx = 1'b1;
        #1;
        chk(shift_en == 1'b0, "rst_shift_en", shift_en, 0);
        chk(shift_din == 1'b0, "rst_shift_din", shift_din, 0);
        chk(rx_done_tick == 1'b0, "rst_done", rx_done_tick, 0);
        chk(frame_err == 1'b0, "rst_err", frame_err, 0);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // Table of whole frames, including framing errors
        for (int k = 0; k < 4; k++) begin
            push_exp(vecs[k].exp_reg, vecs[k].exp_err);
            send_frame(vecs[k].data, vecs[k].stop, 0, 1'b0, ab);
            repeat (100) @(negedge clk);
            chk(busy == 1'b0, "busy_after_frame", busy, 0);
        end

        // Start glitch: low for 3 ticks, back to IDLE on the 8th tick
        s0 = sh_total;
        d0 = done_total;
        @(negedge clk);
        rx = 1'b0;
        @(posedge clk);
        nt = 0;
        while (nt < 8) begin
            @(posedge clk);
            if (s_tick) begin
                nt++;
                if (nt == 7) begin #1; chk(busy == 1'b1, "glitch_busy_t7", busy, 1); end
                if (nt == 8) begin #1; chk(busy == 1'b0, "glitch_idle_t8", busy, 0); end
                if (nt == 3) begin @(negedge clk); rx = 1'b1; end
            end
        end
        repeat (100) @(negedge clk);
        chk(sh_total == s0, "glitch_no_shift", sh_total - s0, 0);
        chk(done_total == d0, "glitch_no_done", done_total - d0, 0);

        // Reset after the third strobe of 0x11, then a clean 0x5A
        send_frame(8'h11, 1'b1, 3, 1'b0, ab);
        chk(ab, "abort_reached", ab, 1);
        rx = 1'b1;
        reset_n = 1'b0;
        #1;
        chk(shift_en == 1'b0, "mid_rst_shift_en", shift_en, 0);
        chk(shift_din == 1'b0, "mid_rst_shift_din", shift_din, 0);
        chk(rx_done_tick == 1'b0, "mid_rst_done", rx_done_tick, 0);
        chk(frame_err == 1'b0, "mid_rst_err", frame_err, 0);
        chk(busy == 1'b0, "mid_rst_busy", busy, 0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        push_exp(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b1, 0, 1'b0, ab);
        repeat (100) @(negedge clk);

        // Back-to-back frames with no idle gap
        push_exp(8'h00, 1'b0);
        send_frame(8'h00, 1'b1, 0, 1'b0, ab);
        push_exp(8'hFF, 1'b0);
        send_frame(8'hFF, 1'b1, 0, 1'b0, ab);
        repeat (100) @(negedge clk);

        // Tick stall mid-DATA
        push_exp(8'hC3, 1'b0);
        send_frame(8'hC3, 1'b1, 0, 1'b1, ab);
        repeat (100) @(negedge clk);

        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        chk(done_total == 8, "done_total", done_total, 8);
        chk(busy == 1'b0, "final_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
